// File: rtl/arm_controller_if.sv
// Instruction/flag inputs and decoded control outputs between arm_controller and the datapath.
// master = datapath side, slave = arm_controller.
interface arm_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        MemWrite;
  logic        PCSrc;
  logic [3:0]  Flags;

  modport master (
    output Instr, ALUFlags,
    input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, MemWrite, PCSrc, Flags
  );

  modport slave (
    input  Instr, ALUFlags,
    output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, MemWrite, PCSrc, Flags
  );
endinterface

// File: rtl/arm_controller.sv
// Single-cycle ARM control unit: instruction decode, NZCV flag register, condition gating.
// Optional ExecCount/SquashCount performance counters when ARM_CTRL_PERF_CNT_EN is defined.
module arm_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  arm_controller_if.slave  bus
`ifdef ARM_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];

  logic unused_instr;
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

  // Main decoder
  logic [1:0] regsrc, immsrc;
  logic       alusrc, memtoreg, regw_main, memw, branch, aluop;

  always_comb begin
    regsrc    = 2'b00;
    immsrc    = 2'b00;
    alusrc    = 1'b0;
    memtoreg  = 1'b0;
    regw_main = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    case (op)
      2'b00: begin
        alusrc    = funct[5];
        regw_main = 1'b1;
        aluop     = 1'b1;
      end
      2'b01: begin
        immsrc = 2'b01;
        alusrc = 1'b1;
        if (funct[0]) begin
          memtoreg  = 1'b1;
          regw_main = 1'b1;
        end else begin
          regsrc = 2'b10;
          memw   = 1'b1;
        end
      end
      2'b10: begin
        regsrc = 2'b01;
        immsrc = 2'b10;
        alusrc = 1'b1;
        branch = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; unsupported commands become a NOP by suppressing the register write
  logic [1:0] alucontrol, flagw;
  logic       cmd_ok, cmd_arith;

  always_comb begin
    alucontrol = 2'b00;
    cmd_ok     = 1'b1;
    cmd_arith  = 1'b0;
    flagw      = 2'b00;
    if (aluop) begin
      case (funct[4:1])
        4'b0100: begin alucontrol = 2'b00; cmd_arith = 1'b1; end
        4'b0010: begin alucontrol = 2'b01; cmd_arith = 1'b1; end
        4'b0000: alucontrol = 2'b10;
        4'b1100: alucontrol = 2'b11;
        default: cmd_ok = 1'b0;
      endcase
      flagw = {funct[0], funct[0] & cmd_arith};
    end
  end

  logic regw, pcs;
  assign regw = regw_main & cmd_ok;
  assign pcs  = branch | (regw & (rd == 4'hF));

  // Condition check against the registered flags
  logic [3:0] flags_q;
  logic       n, z, c, v, condex;
  assign {n, z, c, v} = flags_q;

  always_comb begin
    condex = 1'b0;
    case (cond)
      4'h0: condex = z;
      4'h1: condex = ~z;
      4'h2: condex = c;
      4'h3: condex = ~c;
      4'h4: condex = n;
      4'h5: condex = ~n;
      4'h6: condex = v;
      4'h7: condex = ~v;
      4'h8: condex = c & ~z;
      4'h9: condex = ~c | z;
      4'hA: condex = (n == v);
      4'hB: condex = (n != v);
      4'hC: condex = ~z & (n == v);
      4'hD: condex = z | (n != v);
      4'hE: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (flagw[1] & condex) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (flagw[0] & condex) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.RegSrc     = regsrc;
  assign bus.ImmSrc     = immsrc;
  assign bus.ALUSrc     = alusrc;
  assign bus.ALUControl = alucontrol;
  assign bus.MemtoReg   = memtoreg;
  assign bus.RegWrite   = regw & condex;
  assign bus.MemWrite   = memw & condex;
  assign bus.PCSrc      = pcs & condex;
  assign bus.Flags      = flags_q;

`ifdef ARM_CTRL_PERF_CNT_EN
  // Undefined opcodes never execute, whatever their condition field says
  logic executed;
  assign executed = condex & (op != 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCount   <= '0;
      SquashCount <= '0;
    end else if (executed) begin
      ExecCount   <= ExecCount + 1'b1;
    end else begin
      SquashCount <= SquashCount + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/arm_controller.md
Name: arm_controller

Overview:
- Control unit directly upstream of dataPath in the single-cycle ARM microProcessor.
- Decodes Instr[31:12] into every dataPath control input.
- Holds the architectural NZCV flag register, fed by the dataPath ALU flags.
- Evaluates the 4-bit condition field and gates all state-changing controls (RegWrite, MemWrite, PCSrc, flag update) on the result.

Parameters:
CNT_W, 32, width of the optional performance counters; ignored when ARM_CTRL_PERF_CNT_EN is undefined.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears flag register (and counters)
Instr  input  32  current instruction; only [31:12] used (Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12])
ALUFlags  input  4  {Negative, Zero, Carry, Overflow} from dataPath for current instruction
RegSrc  output  2  register-address selects to dataPath
RegWrite  output  1  register-file write enable, condition-gated
ImmSrc  output  2  extend select: 00 imm8-rot, 01 imm12, 10 imm24 branch
ALUSrc  output  1  1 = immediate operand B
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
MemtoReg  output  1  1 = writeback from ReadData
MemWrite  output  1  data-memory write enable, condition-gated
PCSrc  output  1  1 = PC loads writeback/branch target, condition-gated
Flags  output  4  registered {N,Z,C,V}

Behaviour:
- Timing and reset:
  - Clock is clk; reset is asynchronous and active-high.
  - All outputs except Flags are combinational from Instr and Flags (zero latency).
  - Flags reset to 4'b0000 immediately on reset assertion, independent of clk.
- Main decode (RegSrc, ImmSrc, ALUSrc, MemtoReg, RegW, MemW, Branch, ALUOp):
  - Op=00, Funct[5]=0 (DP reg): 00, 00, 0, 0, 1, 0, 0, 1.
  - Op=00, Funct[5]=1 (DP imm): 00, 00, 1, 0, 1, 0, 0, 1.
  - Op=01, Funct[0]=1 (LDR): 00, 01, 1, 1, 1, 0, 0, 0.
  - Op=01, Funct[0]=0 (STR): 10, 01, 1, 0, 0, 1, 0, 0.
  - Op=10 (B): 01, 10, 1, 0, 0, 0, 1, 0.
  - Op=11: undefined; all enables 0, selects 0.
- ALU decode:
  - ALUOp=0 -> ALUControl=00, FlagW=00.
  - ALUOp=1, cmd=Funct[4:1]: 0100 ADD=00, 0010 SUB=01, 0000 AND=10, 1100 ORR=11.
  - Any other cmd -> ALUControl=00 and RegW forced 0 (treated as NOP).
  - FlagW[1] = Funct[0] (S); updates N,Z.
  - FlagW[0] = S & (ADD|SUB); updates C,V.
- Condition evaluation uses registered Flags, full ARM set:
  - EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - Cond=1111 evaluates as never-execute (CondEx=0).
- Gating:
  - PCS = Branch | (RegW & Rd==4'hF).
  - RegWrite = RegW & CondEx; MemWrite = MemW & CondEx; PCSrc = PCS & CondEx.
- Flag update:
  - On rising clk, Flags[3:2] <= ALUFlags[3:2] if FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0] & CondEx.
  - Otherwise hold.
  - A squashed S-instruction never alters Flags.
- Same-cycle interaction: a flag-setting instruction's condition is judged on the old flags; the new flags affect only the next instruction.
- Reset mid-operation: the flag write of the in-flight instruction is lost; combinational outputs continue to track Instr.

Optional Feature:
- Macro: ARM_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs ExecCount[CNT_W-1:0] and SquashCount[CNT_W-1:0].
  - Both reset to 0 asynchronously.
  - Each rising clk (reset low) increments ExecCount if CondEx=1, else SquashCount.
  - Undefined (Op=11) instructions count as squashed.
  - Both counters wrap from all-ones to 0.
- When undefined: ports and logic are absent; behaviour otherwise identical.

Test Plan:
1. Instr=E2802005 (ADD R2,R0,#5), Flags=0000 -> RegWrite=1, ALUSrc=1, ImmSrc=00, ALUControl=00, MemWrite=0, PCSrc=0; Flags stay 0000 after clock.
2. Instr=E2500001 (SUBS), ALUFlags=0100, clock -> ALUControl=01, Flags=0100; then Instr=0A000002 (BEQ) -> PCSrc=1, ImmSrc=10, RegWrite=0.
3. Flags=0000, Instr=0A000002 -> PCSrc=0. Instr=1A000002 (BNE) -> PCSrc=1.
4. Instr=E5801000 (STR) -> MemWrite=1, RegSrc=10, RegWrite=0. Instr=E5901000 (LDR) -> MemtoReg=1, RegWrite=1, ImmSrc=01.
5. Instr=E280F004 (ADD PC) -> PCSrc=1, RegWrite=1. Instr=F2902005 (cond NV, S set), ALUFlags=1111, clock -> all enables 0, Flags unchanged.
6. Set Flags=1111 via ADDS with ALUFlags=1111, then assert reset between clock edges -> Flags=0000 immediately; with ARM_CTRL_PERF_CNT_EN, counters read 0.
